branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-side partner of the execute-stage branch comparator.
- Predicts taken/not-taken and the target for conditional branches at fetch, using a 2-bit-counter BHT and a tagged direct-mapped BTB.
- Consumes the resolved outcome (the comparator's jump decision plus the computed target) one or more cycles later. On a mispredict it updates state and raises a one-cycle redirect to the PC generator.

Parameters:
- IDX_W, 6, index width; BHT and BTB each have 2^IDX_W entries, indexed by pc[IDX_W+1:2].
- CNT_W, 32, width of each saturating statistics counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- fetch_pc  in  32  PC being fetched this cycle.
- pred_taken  out  1  prediction for fetch_pc (combinational from state).
- pred_target  out  32  predicted next PC for fetch_pc.
- upd_valid  in  1  a conditional branch resolved this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  actual outcome (comparator jump decision).
- upd_target  in  32  actual branch target (pc + B-immediate).
- upd_pred_taken  in  1  prediction that was made for upd_pc, carried down the pipe.
- upd_pred_target  in  32  predicted next PC that was made for upd_pc.
- redirect_valid  out  1  mispredict detected; registered, single-cycle pulse.
- redirect_pc  out  32  correct next PC, valid when redirect_valid is high.
- stat_branches  out  CNT_W  resolved branch count.
- stat_mispred  out  CNT_W  mispredict count.

Behaviour:
- Reset (async, any time, including mid-update): all BHT counters = 2'b01 (weakly not-taken); all BTB valid = 0; redirect_valid = 0; redirect_pc = 32'h0; both stat counters = 0. The first clock edge after rst deasserts is a normal edge.
- Lookup (combinational, zero latency):
  - idx = fetch_pc[IDX_W+1:2]; hit = btb_valid[idx] && btb_tag[idx] == fetch_pc[31:IDX_W+2].
  - pred_taken = hit && bht[idx][1].
  - pred_target = pred_taken ? btb_target[idx] : fetch_pc + 4 (mod 2^32).
- Update (on clk rising edge when upd_valid = 1), with u = upd_pc[IDX_W+1:2]:
  - BHT: if upd_taken, bht[u] = min(bht[u]+1, 3); else bht[u] = max(bht[u]-1, 0). The BHT is untagged.
  - BTB: if upd_taken, write valid = 1, tag = upd_pc[31:IDX_W+2], target = upd_target, overwriting any aliasing entry. A not-taken branch never writes the BTB.
  - actual_next = upd_taken ? upd_target : upd_pc + 4.
  - mispredict = (upd_pred_taken != upd_taken) || (upd_pred_target != actual_next).
  - Next cycle: redirect_valid = mispredict and redirect_pc = actual_next. Otherwise redirect_valid = 0 and redirect_pc holds its last value.
  - stat_branches += 1. stat_mispred += mispredict. Both saturate at all-ones and never wrap.
- upd_valid = 0: no state change; redirect_valid = 0 next cycle.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents (read-old). The new contents are visible from the next cycle.
- Counter saturation: bht at 3 plus taken stays 3; bht at 0 plus not-taken stays 0.
- No back-pressure: one update is accepted per cycle, every cycle.

Decomposition:
- Shared package:
  - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
  - BHT reset value WNT;
  - instruction step constant 32'd4.
- One natural sub-module: sat_counter2, the 2-bit saturating up/down counter with async reset to WNT, instantiated 2^IDX_W times.
- BTB arrays and statistics stay in the top level.

Test Plan:
1. Cold predict: after reset, fetch_pc = 32'h0000_0100 -> pred_taken = 0, pred_target = 32'h0000_0104.
2. Training: three taken updates at upd_pc = 32'h100, upd_target = 32'h80, each predicted not-taken.
   - Cycle 1: redirect_valid = 1, redirect_pc = 32'h80.
   - Afterwards fetch_pc = 32'h100 -> pred_taken = 1, pred_target = 32'h80; bht = ST.
   - Then one not-taken update -> bht = WT, still predicts taken, redirect_pc = 32'h104.
3. Alias: train 32'h100 taken to 32'h80, then fetch_pc = 32'h200 (same idx when IDX_W = 6, different tag) -> pred_taken = 0, pred_target = 32'h204.
4. Target mismatch: upd_pred_taken = 1, upd_pred_target = 32'h80, actual taken to 32'h90 -> redirect_valid = 1, redirect_pc = 32'h90, BTB target updated to 32'h90.
5. Same-cycle read/write: lookup 32'h100 during the first training update -> pred_taken = 0 that cycle; updated state is visible the next cycle.
6. Async reset mid-stream: assert rst between clock edges while redirect_valid = 1 -> redirect_valid, stat_branches and stat_mispred drop to 0 immediately; a subsequent lookup of 32'h100 predicts not-taken.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-side branch predictor.
//
// Contents:
//   bht_cnt_e  - 2-bit branch history counter encoding.
//                SNT = strongly not-taken, WNT = weakly not-taken,
//                WT = weakly taken, ST = strongly taken.
//   BHT_RESET  - value every history counter takes on reset.
//   INSN_STEP  - byte distance to the next sequential instruction.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_cnt_e;

    localparam bht_cnt_e    BHT_RESET = WNT;
    localparam logic [31:0] INSN_STEP = 32'd4;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Two-bit saturating up/down counter, one per branch history table entry.
//
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset, counter returns to BHT_RESET
//   en_i   in   apply a step this cycle
//   up_i   in   step direction: 1 = towards ST, 0 = towards SNT
//   cnt_o  out  current counter state
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     en_i,
    input  logic     up_i,
    output bht_cnt_e cnt_o
);

    bht_cnt_e cnt_q;
    bht_cnt_e cnt_d;

    // Step towards the requested end; the two extreme states absorb
    // further steps in their own direction instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            if (up_i) begin
                if (cnt_q != ST) begin
                    cnt_d = bht_cnt_e'(cnt_q + 2'b01);
                end
            end else begin
                if (cnt_q != SNT) begin
                    cnt_d = bht_cnt_e'(cnt_q - 2'b01);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= BHT_RESET;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: 2-bit counter BHT plus tagged direct-mapped
// BTB. Predicts direction and target for the fetch PC combinationally and
// learns from resolved branches reported by the execute-stage comparator.
// A mispredicted branch raises a one-cycle registered redirect carrying the
// correct next PC.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   fetch_pc                     PC being fetched this cycle
//   pred_taken, pred_target      prediction for fetch_pc (combinational)
//   upd_valid                    a conditional branch resolved this cycle
//   upd_pc, upd_taken,
//   upd_target                   resolved branch PC, outcome and target
//   upd_pred_taken,
//   upd_pred_target              prediction that was made for upd_pc
//   redirect_valid, redirect_pc  registered mispredict pulse and correct PC
//   stat_branches, stat_mispred  saturating resolved/mispredict counters
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      fetch_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_pred_taken,
    input  logic [31:0]      upd_pred_target,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispred
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 32 - IDX_W - 2;

    logic [IDX_W-1:0] fetchIdx;
    logic [TAG_W-1:0] fetchTag;
    logic [IDX_W-1:0] updIdx;
    logic [TAG_W-1:0] updTag;

    bht_cnt_e         bhtCnt [ENTRIES];

    logic [ENTRIES-1:0] btbValid_q;
    logic [TAG_W-1:0]   btbTag_q    [ENTRIES];
    logic [31:0]        btbTarget_q [ENTRIES];

    logic               btbHit;
    logic [31:0]        actualNext;
    logic               mispredict;

    logic               redirectValid_q;
    logic [31:0]        redirectPc_q;
    logic [CNT_W-1:0]   statBranches_q;
    logic [CNT_W-1:0]   statMispred_q;

    assign fetchIdx = fetch_pc[IDX_W+1:2];
    assign fetchTag = fetch_pc[31:IDX_W+2];
    assign updIdx   = upd_pc[IDX_W+1:2];
    assign updTag   = upd_pc[31:IDX_W+2];

    // The history table is untagged: aliasing branches share a counter.
    for (genvar i = 0; i < ENTRIES; i++) begin : g_bht
        sat_counter2 u_cnt (
            .clk   (clk),
            .rst   (rst),
            .en_i  (upd_valid && (updIdx == IDX_W'(i))),
            .up_i  (upd_taken),
            .cnt_o (bhtCnt[i])
        );
    end

    // Lookup reads registered state only, so a same-cycle update to the
    // same entry is seen from the following cycle.
    assign btbHit      = btbValid_q[fetchIdx] && (btbTag_q[fetchIdx] == fetchTag);
    assign pred_taken  = btbHit && bhtCnt[fetchIdx][1];
    assign pred_target = pred_taken ? btbTarget_q[fetchIdx] : fetch_pc + INSN_STEP;

    // Only the valid bits need a reset; tag and target are ignored while
    // the entry is invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btbValid_q <= '0;
        end else if (upd_valid && upd_taken) begin
            btbValid_q[updIdx] <= 1'b1;
        end
    end

    // Taken branches claim the entry outright, evicting any alias.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            btbTag_q[updIdx]    <= updTag;
            btbTarget_q[updIdx] <= upd_target;
        end
    end

    // A prediction is wrong if either the direction or the next PC the
    // front end actually followed differs from the resolved outcome.
    assign actualNext = upd_taken ? upd_target : upd_pc + INSN_STEP;
    assign mispredict = (upd_pred_taken != upd_taken) || (upd_pred_target != actualNext);

    // The redirect PC is only refreshed on a mispredict, otherwise it
    // keeps the last corrected PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirectValid_q <= 1'b0;
            redirectPc_q    <= 32'h0;
        end else begin
            redirectValid_q <= upd_valid && mispredict;
            if (upd_valid && mispredict) begin
                redirectPc_q <= actualNext;
            end
        end
    end

    // Statistics stick at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            statBranches_q <= '0;
            statMispred_q  <= '0;
        end else if (upd_valid) begin
            if (statBranches_q != '1) begin
                statBranches_q <= statBranches_q + 1'b1;
            end
            if (mispredict && (statMispred_q != '1)) begin
                statMispred_q <= statMispred_q + 1'b1;
            end
        end
    end

    assign redirect_valid = redirectValid_q;
    assign redirect_pc    = redirectPc_q;
    assign stat_branches  = statBranches_q;
    assign stat_mispred   = statMispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor: cold prediction, training,
// counter saturation at both ends, BTB aliasing and overwrite, target
// mismatch, same-cycle read-old behaviour and asynchronous reset.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;

    int checks   = 0;
    int failures = 0;

    branch_predictor #(.IDX_W(6), .CNT_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_pc        (fetch_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .stat_branches   (stat_branches),
        .stat_mispred    (stat_mispred)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one resolved-branch report onto the update port.
    task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                                 input logic taken, input logic [31:0] target,
                                 input logic predTaken, input logic [31:0] predTarget);
        upd_valid       = valid;
        upd_pc          = pc;
        upd_taken       = taken;
        upd_target      = target;
        upd_pred_taken  = predTaken;
        upd_pred_target = predTarget;
    endtask

    // Advance to just after the next rising edge.
    task automatic clockStep();
        @(posedge clk);
        #1;
    endtask

    // Present a fetch PC and compare the combinational prediction.
    task automatic checkPredict(input string tag, input logic [31:0] pc,
                                input logic expTaken, input logic [31:0] expTarget);
        fetch_pc = pc;
        #1;
        checkOutput({tag, ".taken"}, {31'b0, pred_taken}, {31'b0, expTaken});
        checkOutput({tag, ".target"}, pred_target, expTarget);
    endtask

    task automatic checkRedirect(input string tag, input logic expValid,
                                 input logic [31:0] expPc, input logic checkPc);
        checkOutput({tag, ".rvalid"}, {31'b0, redirect_valid}, {31'b0, expValid});
        if (checkPc) checkOutput({tag, ".rpc"}, redirect_pc, expPc);
    endtask

    task automatic checkStats(input string tag, input int expBranches, input int expMispred);
        checkOutput({tag, ".branches"}, stat_branches, 32'(expBranches));
        checkOutput({tag, ".mispred"}, stat_mispred, 32'(expMispred));
    endtask

    initial begin
        rst      = 1'b1;
        fetch_pc = 32'h0;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #12;

        // Reset state
        checkRedirect("reset", 1'b0, 32'h0, 1'b1);
        checkStats("reset", 0, 0);
        rst = 1'b0;

        // Cold predict
        checkPredict("cold", 32'h100, 1'b0, 32'h104);

        // First training update with a same-cycle lookup of the same PC
        applyStimulus(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        #1;
        checkOutput("rdold.taken", {31'b0, pred_taken}, 32'd0);
        checkOutput("rdold.target", pred_target, 32'h104);
        clockStep();
        checkRedirect("train1", 1'b1, 32'h80, 1'b1);
        checkStats("train1", 1, 1);
        checkPredict("train1", 32'h100, 1'b1, 32'h80);

        applyStimulus(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        clockStep();
        checkRedirect("train2", 1'b1, 32'h80, 1'b1);
        checkPredict("train2", 32'h100, 1'b1, 32'h80);

        // Third taken pushes against the ST ceiling
        applyStimulus(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        clockStep();
        checkStats("train3", 3, 3);
        checkPredict("train3", 32'h100, 1'b1, 32'h80);

        // Idle cycle clears the redirect pulse
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        clockStep();
        checkRedirect("idle", 1'b0, 32'h0, 1'b0);
        checkStats("idle", 3, 3);

        // Not-taken from ST lands on WT and still predicts taken
        applyStimulus(1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        clockStep();
        checkRedirect("nt", 1'b1, 32'h104, 1'b1);
        checkStats("nt", 4, 4);
        checkPredict("nt", 32'h100, 1'b1, 32'h80);

        // Correctly predicted taken branch
        applyStimulus(1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        clockStep();
        checkRedirect("hit", 1'b0, 32'h0, 1'b0);
        checkStats("hit", 5, 4);

        // Alias: same index, different tag misses the BTB
        checkPredict("alias", 32'h200, 1'b0, 32'h204);

        // Direction right, target wrong
        applyStimulus(1'b1, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
        clockStep();
        checkRedirect("tgt", 1'b1, 32'h90, 1'b1);
        checkStats("tgt", 6, 5);
        checkPredict("tgt", 32'h100, 1'b1, 32'h90);

        // Taken alias evicts the previous BTB owner
        applyStimulus(1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
        clockStep();
        checkRedirect("evict", 1'b1, 32'h300, 1'b1);
        checkStats("evict", 7, 6);
        checkPredict("evict.old", 32'h100, 1'b0, 32'h104);
        checkPredict("evict.new", 32'h200, 1'b1, 32'h300);

        // Index 1: two not-takens drive WNT to the SNT floor
        applyStimulus(1'b1, 32'h104, 1'b0, 32'h44, 1'b0, 32'h108);
        clockStep();
        checkRedirect("floor1", 1'b0, 32'h0, 1'b0);
        checkPredict("floor1", 32'h104, 1'b0, 32'h108);
        applyStimulus(1'b1, 32'h104, 1'b0, 32'h44, 1'b0, 32'h108);
        clockStep();
        checkRedirect("floor2", 1'b0, 32'h0, 1'b0);
        checkStats("floor2", 9, 6);

        // SNT -> WNT: BTB now hits but the counter still says not-taken
        applyStimulus(1'b1, 32'h104, 1'b1, 32'h40, 1'b0, 32'h108);
        clockStep();
        checkRedirect("rise1", 1'b1, 32'h40, 1'b1);
        checkStats("rise1", 10, 7);
        checkPredict("rise1", 32'h104, 1'b0, 32'h108);

        // WNT -> WT: now predicts taken
        applyStimulus(1'b1, 32'h104, 1'b1, 32'h40, 1'b0, 32'h108);
        clockStep();
        checkRedirect("rise2", 1'b1, 32'h40, 1'b1);
        checkStats("rise2", 11, 8);
        checkPredict("rise2", 32'h104, 1'b1, 32'h40);

        // Async reset while the redirect pulse is high
        applyStimulus(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        clockStep();
        checkRedirect("prerst", 1'b1, 32'h80, 1'b1);
        checkStats("prerst", 12, 9);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        checkRedirect("asyncrst", 1'b0, 32'h0, 1'b1);
        checkStats("asyncrst", 0, 0);
        checkPredict("asyncrst.a", 32'h100, 1'b0, 32'h104);
        checkPredict("asyncrst.b", 32'h200, 1'b0, 32'h204);
        rst = 1'b0;
        clockStep();
        checkRedirect("postrst", 1'b0, 32'h0, 1'b1);
        checkStats("postrst", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
